gpu_instr_fifo: RTL and testbench

Instruction buffer between the software-facing PIO registers and the GPU instruction decoder. It captures the two 32-bit PIO words (data A, data B) as one 64-bit instruction when the write-strobe PIO bit rises, queues it in a FIFO, and presents instructions to the decoder with a valid/ready handshake. It reports full/empty/level so software can poll before issuing the next instruction.

---
 rtl/gpu_instr_fifo.sv | 108 ++++++++++
 tb/tb_gpu_instr_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gpu_instr_fifo.sv
// Instruction FIFO between the PIO data/strobe registers and the GPU decoder.
// Define GPU_INSTR_FIFO_DROP_COUNT_EN to build the saturating dropped-push counter.
module gpu_instr_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_a,
  input  logic [DATA_W-1:0]       data_b,
  input  logic                    wrreg,
  output logic [2*DATA_W-1:0]     instr_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [DEPTH_LOG2:0]     level,
  output logic [15:0]             drop_count
);

  localparam int                 DEPTH   = 1 << DEPTH_LOG2;
  localparam int                 PW      = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]      PTR_ONE = PW'(1);

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   wrreg_q, wrreg_d;
  logic [2*DATA_W-1:0]    mem_q [DEPTH];
  logic                   push_req_s, push_s, pop_s, full_s, empty_s;

  // Full when the pointers sit on the same slot but on opposite laps.
  assign full_s     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign push_req_s = wrreg & ~wrreg_q;
  assign push_s     = push_req_s & ~full_s;
  assign pop_s      = ~empty_s & instr_ready;

  assign instr_out   = mem_q[rd_ptr_q[PW-2:0]];
  assign instr_valid = ~empty_s;
  assign fifo_full   = full_s;
  assign fifo_empty  = empty_s;
  assign level       = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wrreg_d  = wrreg;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // wrreg_q resets high so a strobe held across reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wrreg_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wrreg_q  <= wrreg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[PW-2:0]] <= {data_b, data_a};
    end
  end

`ifdef GPU_INSTR_FIFO_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_s;

  assign drop_s = push_req_s & full_s;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_gpu_instr_fifo.sv
// Directed self-checking bench for gpu_instr_fifo.
module tb_gpu_instr_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_a, data_b;
  logic        wrreg, instr_ready;
  logic [63:0] instr_out;
  logic        instr_valid, fifo_full, fifo_empty;
  logic [4:0]  level;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] q[$];
  logic [15:0] drops_exp;

  gpu_instr_fifo #(.DEPTH_LOG2(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .data_a(data_a), .data_b(data_b), .wrreg(wrreg),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    data_a = a;
    data_b = b;
    wrreg  = 1'b1;
    step();
    wrreg  = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; wrreg = 1'b1; instr_ready = 1'b0;
    data_a = 32'h0; data_b = 32'h0;
`ifdef GPU_INSTR_FIFO_DROP_COUNT_EN
    drops_exp = 16'd1;
`else
    drops_exp = 16'd0;
`endif
    repeat (3) step();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // Release reset with the strobe still high: must not enqueue.
    reset = 1'b0;
    repeat (3) step();
    chk("hold_level", 64'(level), 64'd0);
    chk("hold_empty", 64'(fifo_empty), 64'd1);
    chk("hold_valid", 64'(instr_valid), 64'd0);
    wrreg = 1'b0;
    step();

    // One long strobe pulse produces exactly one entry.
    data_a = 32'h0000_0011; data_b = 32'hAABB_CCDD; wrreg = 1'b1;
    step();
    step();
    chk("one_level", 64'(level), 64'd1);
    chk("one_valid", 64'(instr_valid), 64'd1);
    chk("one_data", instr_out, 64'hAABB_CCDD_0000_0011);
    repeat (3) step();
    chk("one_level_hold", 64'(level), 64'd1);
    wrreg = 1'b0;
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("one_drained", 64'(fifo_empty), 64'd1);

    // Fill to 16, then one dropped push.
    for (int i = 0; i < 16; i++) push(32'h0000_0100 + 32'(i), 32'hB000_0000 + 32'(i));
    chk("full_flag", 64'(fifo_full), 64'd1);
    chk("full_level", 64'(level), 64'd16);
    chk("full_head", instr_out, 64'hB000_0000_0000_0100);
    push(32'hDEAD_0000, 32'hDEAD_0001);
    chk("drop_level", 64'(level), 64'd16);
    chk("drop_cnt1", 64'(drop_count), 64'(drops_exp));
    chk("drop_head", instr_out, 64'hB000_0000_0000_0100);

    // Push coincident with pop while full is still dropped.
    data_a = 32'hBEEF_0000; data_b = 32'hBEEF_0001;
    wrreg = 1'b1; instr_ready = 1'b1;
    step();
    wrreg = 1'b0; instr_ready = 1'b0;
    step();
    chk("popfull_level", 64'(level), 64'd15);
    chk("popfull_head", instr_out, 64'hB000_0001_0000_0101);
    chk("popfull_drop", 64'(drop_count), 64'(drops_exp * 16'd2));

    // Drain the remaining 15 in order.
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", instr_out, {32'hB000_0000 + 32'(i), 32'h0000_0100 + 32'(i)});
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
    end
    chk("drain_empty", 64'(fifo_empty), 64'd1);
    chk("drain_valid", 64'(instr_valid), 64'd0);

    // Level 5, then 40 simultaneous push/pop cycles across the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      push(32'hC000_0000 + 32'(i), 32'h5000_0000 + 32'(i));
      q.push_back({32'h5000_0000 + 32'(i), 32'hC000_0000 + 32'(i)});
    end
    chk("l5_level", 64'(level), 64'd5);
    for (int i = 5; i < 45; i++) begin
      chk("wrap_head", instr_out, q[0]);
      data_a = 32'hC000_0000 + 32'(i); data_b = 32'h5000_0000 + 32'(i);
      wrreg = 1'b1; instr_ready = 1'b1;
      step();
      wrreg = 1'b0; instr_ready = 1'b0;
      void'(q.pop_front());
      q.push_back({data_b, data_a});
      chk("wrap_level", 64'(level), 64'd5);
      step();
    end
    while (q.size() > 0) begin
      chk("wrap_tail", instr_out, q[0]);
      void'(q.pop_front());
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
    end
    chk("wrap_empty", 64'(fifo_empty), 64'd1);

    // Build level 7 and reset asynchronously in the middle of a further push.
    for (int i = 0; i < 7; i++) push(32'hE000_0000 + 32'(i), 32'h7000_0000 + 32'(i));
    chk("l7_level", 64'(level), 64'd7);
    data_a = 32'hE000_0007; data_b = 32'h7000_0007; wrreg = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("async_level", 64'(level), 64'd0);
    chk("async_empty", 64'(fifo_empty), 64'd1);
    chk("async_valid", 64'(instr_valid), 64'd0);
    chk("async_drop", 64'(drop_count), 64'd0);
    wrreg = 1'b0;
    step();
    reset = 1'b0;
    step();
    push(32'h1234_5678, 32'h9ABC_DEF0);
    chk("restart_level", 64'(level), 64'd1);
    chk("restart_data", instr_out, 64'h9ABC_DEF0_1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
